// File: rtl/sdram_avalon_master_if.sv
// sdram_avalon_master_if
//   Bundles the CPU-side request/response signals and the Avalon-MM
//   controller-side signals of sdram_avalon_master.
//   master modport: the view of the sdram_avalon_master block itself
//     (CPU request inputs, CPU response outputs, Avalon command outputs,
//     Avalon read-return and waitrequest inputs).
//   slave modport: the view of whatever surrounds it (CPU plus controller).
interface sdram_avalon_master_if;
    // CPU side
    logic        cpu_req;
    logic        cpu_we;
    logic [26:0] cpu_addr;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        busy;
    logic        err_spurious;
    // Avalon-MM side towards the SDRAM controller
    logic [24:0] controller_address;
    logic [3:0]  controller_byteenable_n;
    logic        controller_chipselect;
    logic [31:0] controller_writedata;
    logic        controller_read_n;
    logic        controller_write_n;
    logic [31:0] controller_readdata;
    logic        controller_readdatavalid;
    logic        controller_waitrequest;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
        output cpu_ready, cpu_rvalid, cpu_rdata, busy, err_spurious,
        output controller_address, controller_byteenable_n, controller_chipselect,
        output controller_writedata, controller_read_n, controller_write_n,
        input  controller_readdata, controller_readdatavalid, controller_waitrequest
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata, busy, err_spurious,
        input  controller_address, controller_byteenable_n, controller_chipselect,
        input  controller_writedata, controller_read_n, controller_write_n,
        output controller_readdata, controller_readdatavalid, controller_waitrequest
    );
endinterface

// File: rtl/sdram_avalon_master.sv
// sdram_avalon_master
//   Avalon-MM master driving the SDRAM controller slave port for the
//   RISC-V data-memory path. Converts a CPU request/ready interface
//   (byte address, active-high byte enables) into registered Avalon
//   read/write commands, honours waitrequest and keeps up to MAX_RD reads
//   in flight. Read data is returned in order, one cycle after
//   controller_readdatavalid.
// Ports:
//   clk_clk      : single clock, rising edge
//   reset_reset  : synchronous active-high reset
//   bus          : sdram_avalon_master_if.master (CPU request/response,
//                  busy, err_spurious, Avalon command and read-return)
module sdram_avalon_master #(
    parameter int MAX_RD = 4
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    sdram_avalon_master_if.master         bus
);
    localparam int            CW       = $clog2(MAX_RD + 1);
    localparam logic [CW:0]   MAX_RD_W = MAX_RD[CW:0];
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CMD  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic          cs_q, cs_d;
    logic          read_n_q, read_n_d;
    logic          write_n_q, write_n_d;
    logic [24:0]   addr_q, addr_d;
    logic [3:0]    ben_n_q, ben_n_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          accept_slot, cmd_done, rd_done, rd_ret, spurious;
    logic          cpu_ready, accept;
    logic [CW:0]   rd_need;
    logic          addr_lsb_unused;

    // Word addressing only: the byte offset within the word is dropped.
    assign addr_lsb_unused = ^bus.cpu_addr[1:0];

    always_comb begin
        accept_slot = (state_q == S_IDLE) || !bus.controller_waitrequest;
        cmd_done    = (state_q == S_CMD) && !bus.controller_waitrequest;
        rd_done     = cmd_done && !read_n_q;
        // A read finishing on this edge already occupies a slot; a return on
        // the same edge is not credited, which keeps cpu_ready off the
        // readdatavalid path.
        rd_need     = {1'b0, rd_cnt_q} + {{CW{1'b0}}, rd_done};
        cpu_ready   = !reset_reset && accept_slot && (bus.cpu_we || (rd_need < MAX_RD_W));
        accept      = bus.cpu_req && cpu_ready;
        rd_ret      = bus.controller_readdatavalid && (rd_cnt_q != '0);
        spurious    = bus.controller_readdatavalid && (rd_cnt_q == '0);

        state_d   = state_q;
        cs_d      = cs_q;
        read_n_d  = read_n_q;
        write_n_d = write_n_q;
        addr_d    = addr_q;
        ben_n_d   = ben_n_q;
        wdata_d   = wdata_q;

        if (accept && !bus.cpu_we) begin
            // Reads always fetch the full word.
            state_d   = S_CMD;
            cs_d      = 1'b1;
            read_n_d  = 1'b0;
            write_n_d = 1'b1;
            addr_d    = bus.cpu_addr[26:2];
            ben_n_d   = 4'h0;
        end else if (accept && (bus.cpu_be != 4'h0)) begin
            state_d   = S_CMD;
            cs_d      = 1'b1;
            read_n_d  = 1'b1;
            write_n_d = 1'b0;
            addr_d    = bus.cpu_addr[26:2];
            ben_n_d   = ~bus.cpu_be;
            wdata_d   = bus.cpu_wdata;
        end else if (accept || cmd_done) begin
            // Empty write (no bytes enabled) is swallowed, or the last
            // command finished with nothing new behind it.
            state_d   = S_IDLE;
            cs_d      = 1'b0;
            read_n_d  = 1'b1;
            write_n_d = 1'b1;
        end

        case ({rd_done, rd_ret})
            2'b10:   rd_cnt_d = rd_cnt_q + CNT_ONE;
            2'b01:   rd_cnt_d = rd_cnt_q - CNT_ONE;
            default: rd_cnt_d = rd_cnt_q;
        endcase

        rvalid_d = rd_ret;
        rdata_d  = rd_ret ? bus.controller_readdata : rdata_q;
        err_d    = err_q || spurious;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q   <= S_IDLE;
            rd_cnt_q  <= '0;
            cs_q      <= 1'b0;
            read_n_q  <= 1'b1;
            write_n_q <= 1'b1;
            addr_q    <= '0;
            ben_n_q   <= 4'hF;
            wdata_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            cs_q      <= cs_d;
            read_n_q  <= read_n_d;
            write_n_q <= write_n_d;
            addr_q    <= addr_d;
            ben_n_q   <= ben_n_d;
            wdata_q   <= wdata_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign bus.cpu_ready               = cpu_ready;
    assign bus.cpu_rvalid              = rvalid_q;
    assign bus.cpu_rdata               = rdata_q;
    assign bus.busy                    = (state_q == S_CMD) || (rd_cnt_q != '0);
    assign bus.err_spurious            = err_q;
    assign bus.controller_address      = addr_q;
    assign bus.controller_byteenable_n = ben_n_q;
    assign bus.controller_chipselect   = cs_q;
    assign bus.controller_writedata    = wdata_q;
    assign bus.controller_read_n       = read_n_q;
    assign bus.controller_write_n      = write_n_q;
endmodule

// File: tb/tb_sdram_avalon_master.sv
module tb_sdram_avalon_master;
    localparam int MAX_RD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdram_avalon_master_if bus();

    sdram_avalon_master #(.MAX_RD(MAX_RD)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .bus         (bus.master)
    );

    int nerr = 0;
    int nchk = 0;

    typedef struct {
        logic        we;
        logic [26:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [24:0] e_addr;
        logic [3:0]  e_ben_n;
        logic        e_cs;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs[6];

    typedef struct {
        int          due;
        logic [31:0] d;
    } ret_t;
    ret_t pend[$];
    ret_t r;

    typedef struct {
        logic        valid;
        logic        is_rd;
        logic [24:0] addr;
        logic [3:0]  ben_n;
        logic [31:0] wdata;
    } cmd_t;
    cmd_t cur;

    int          acc[6];
    int          sent, nc, got, ret0, outst;
    logic        w, rdv, rdv_prev, acc_now, exp_rdy;
    logic [31:0] rd_prev;

    task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
        nchk++;
        if (got_v !== exp_v) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.cpu_req                  = 1'b0;
        bus.cpu_we                   = 1'b0;
        bus.cpu_addr                 = '0;
        bus.cpu_be                   = '0;
        bus.cpu_wdata                = '0;
        bus.controller_readdata      = '0;
        bus.controller_readdatavalid = 1'b0;
        bus.controller_waitrequest   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // we, addr, be, wdata, exp word addr, exp byteenable_n, exp chipselect, read data
        vecs[0] = '{1'b0, 27'h7FFFFFC, 4'hF, 32'h0,        25'h1FFFFFF, 4'h0,    1'b1, 32'h0BADF00D};
        vecs[1] = '{1'b0, 27'h0000003, 4'h5, 32'h0,        25'h0000000, 4'h0,    1'b1, 32'h76543210};
        vecs[2] = '{1'b1, 27'h4000006, 4'h8, 32'hA5A5A5A5, 25'h1000001, 4'b0111, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 27'h0000010, 4'hF, 32'h01020304, 25'h0000004, 4'h0,    1'b1, 32'h0};
        vecs[4] = '{1'b1, 27'h0000020, 4'h0, 32'hFFFFFFFF, 25'h0000000, 4'h0,    1'b0, 32'h0};
        vecs[5] = '{1'b0, 27'h1234568, 4'h0, 32'h0,        25'h048D15A, 4'h0,    1'b1, 32'hFEEDC0DE};

        // ---------------- reset ----------------
        set_idle();
        rst = 1'b1;
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b1;
        bus.cpu_be  = 4'hF;
        repeat (2) begin
            @(negedge clk);
            chk("ready_in_reset", 32'(bus.cpu_ready), 0);
            tick();
        end
        rst = 1'b0;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("rst_cs",     32'(bus.controller_chipselect), 0);
        chk("rst_read_n", 32'(bus.controller_read_n), 1);
        chk("rst_write_n",32'(bus.controller_write_n), 1);
        chk("rst_ben_n",  32'(bus.controller_byteenable_n), 32'hF);
        chk("rst_addr",   32'(bus.controller_address), 0);
        chk("rst_wdata",  bus.controller_writedata, 0);
        chk("rst_rvalid", 32'(bus.cpu_rvalid), 0);
        chk("rst_rdata",  bus.cpu_rdata, 0);
        chk("rst_err",    32'(bus.err_spurious), 0);
        chk("rst_busy",   32'(bus.busy), 0);
        chk("ready_after_reset", 32'(bus.cpu_ready), 1);
        tick();

        // ---------------- table-driven single commands ----------------
        for (int i = 0; i < 6; i++) begin
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = vecs[i].we;
            bus.cpu_addr  = vecs[i].addr;
            bus.cpu_be    = vecs[i].be;
            bus.cpu_wdata = vecs[i].wdata;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 32'(bus.cpu_ready), 1);
            tick();
            bus.cpu_req = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_cs", i), 32'(bus.controller_chipselect), 32'(vecs[i].e_cs));
            chk($sformatf("vec%0d_read_n", i), 32'(bus.controller_read_n),
                vecs[i].e_cs ? 32'(vecs[i].we) : 1);
            chk($sformatf("vec%0d_write_n", i), 32'(bus.controller_write_n),
                vecs[i].e_cs ? 32'(!vecs[i].we) : 1);
            if (vecs[i].e_cs) begin
                chk($sformatf("vec%0d_addr", i), 32'(bus.controller_address), 32'(vecs[i].e_addr));
                chk($sformatf("vec%0d_ben_n", i), 32'(bus.controller_byteenable_n), 32'(vecs[i].e_ben_n));
                if (vecs[i].we)
                    chk($sformatf("vec%0d_wdata", i), bus.controller_writedata, vecs[i].wdata);
            end
            tick();
            if (!vecs[i].we) begin
                bus.controller_readdatavalid = 1'b1;
                bus.controller_readdata      = vecs[i].rdata;
                tick();
                bus.controller_readdatavalid = 1'b0;
                bus.controller_readdata      = '0;
                @(negedge clk);
                chk($sformatf("vec%0d_rvalid", i), 32'(bus.cpu_rvalid), 1);
                chk($sformatf("vec%0d_rdata", i), bus.cpu_rdata, vecs[i].rdata);
                tick();
            end
            @(negedge clk);
            chk($sformatf("vec%0d_busy_end", i), 32'(bus.busy), 0);
            chk($sformatf("vec%0d_rvalid_end", i), 32'(bus.cpu_rvalid), 0);
            tick();
        end

        // ---------------- single read, return 3 cycles after accept ----------------
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 27'h0000104;
        bus.cpu_be   = 4'hA;
        @(negedge clk);
        chk("rd1_ready", 32'(bus.cpu_ready), 1);
        tick();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("rd1_cs",     32'(bus.controller_chipselect), 1);
        chk("rd1_read_n", 32'(bus.controller_read_n), 0);
        chk("rd1_write_n",32'(bus.controller_write_n), 1);
        chk("rd1_addr",   32'(bus.controller_address), 32'h41);
        chk("rd1_ben_n",  32'(bus.controller_byteenable_n), 0);
        tick();
        @(negedge clk);
        chk("rd1_cs_off", 32'(bus.controller_chipselect), 0);
        chk("rd1_busy_outstanding", 32'(bus.busy), 1);
        tick();
        bus.controller_readdatavalid = 1'b1;
        bus.controller_readdata      = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd1_rvalid_early", 32'(bus.cpu_rvalid), 0);
        tick();
        bus.controller_readdatavalid = 1'b0;
        bus.controller_readdata      = '0;
        @(negedge clk);
        chk("rd1_rvalid", 32'(bus.cpu_rvalid), 1);
        chk("rd1_rdata",  bus.cpu_rdata, 32'hDEADBEEF);
        chk("rd1_busy_done", 32'(bus.busy), 0);
        tick();
        @(negedge clk);
        chk("rd1_rvalid_pulse", 32'(bus.cpu_rvalid), 0);
        tick();

        // ---------------- write held by waitrequest ----------------
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_be    = 4'b0011;
        bus.cpu_addr  = 27'h0000200;
        bus.cpu_wdata = 32'h12345678;
        bus.controller_waitrequest = 1'b1;
        @(negedge clk);
        chk("ww_ready_idle", 32'(bus.cpu_ready), 1);
        tick();
        bus.cpu_be    = 4'hF;
        bus.cpu_addr  = 27'h0000300;
        bus.cpu_wdata = 32'hCAFEF00D;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("ww_hold%0d_cs", k),      32'(bus.controller_chipselect), 1);
            chk($sformatf("ww_hold%0d_write_n", k), 32'(bus.controller_write_n), 0);
            chk($sformatf("ww_hold%0d_read_n", k),  32'(bus.controller_read_n), 1);
            chk($sformatf("ww_hold%0d_ben_n", k),   32'(bus.controller_byteenable_n), 32'b1100);
            chk($sformatf("ww_hold%0d_addr", k),    32'(bus.controller_address), 32'h80);
            chk($sformatf("ww_hold%0d_wdata", k),   bus.controller_writedata, 32'h12345678);
            chk($sformatf("ww_hold%0d_ready", k),   32'(bus.cpu_ready), 0);
            tick();
        end
        bus.controller_waitrequest = 1'b0;
        @(negedge clk);
        chk("ww_last_addr", 32'(bus.controller_address), 32'h80);
        chk("ww_ready_release", 32'(bus.cpu_ready), 1);
        tick();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("ww_b2b_cs",    32'(bus.controller_chipselect), 1);
        chk("ww_b2b_addr",  32'(bus.controller_address), 32'hC0);
        chk("ww_b2b_ben_n", 32'(bus.controller_byteenable_n), 0);
        chk("ww_b2b_wdata", bus.controller_writedata, 32'hCAFEF00D);
        tick();
        @(negedge clk);
        chk("ww_idle_cs",   32'(bus.controller_chipselect), 0);
        chk("ww_idle_busy", 32'(bus.busy), 0);
        tick();

        // ---------------- write with no byte enables ----------------
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_be    = 4'h0;
        bus.cpu_addr  = 27'h0000555;
        bus.cpu_wdata = 32'h55555555;
        @(negedge clk);
        chk("zbe_ready", 32'(bus.cpu_ready), 1);
        tick();
        bus.cpu_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("zbe_cs%0d", k),   32'(bus.controller_chipselect), 0);
            chk($sformatf("zbe_busy%0d", k), 32'(bus.busy), 0);
            tick();
        end

        // ---------------- pipelined reads, latency 5 ----------------
        pend.delete();
        sent = 0; nc = 0; got = 0; ret0 = -1;
        for (int c = 0; c < 60 && got < 6; c++) begin
            bus.cpu_req  = (sent < 6);
            bus.cpu_we   = 1'b0;
            bus.cpu_be   = 4'hF;
            bus.cpu_addr = 27'(32'h1000 + sent * 4);
            bus.controller_waitrequest = 1'b0;
            if (pend.size() > 0 && pend[0].due <= c) begin
                bus.controller_readdatavalid = 1'b1;
                bus.controller_readdata      = pend[0].d;
                void'(pend.pop_front());
                if (ret0 < 0) ret0 = c;
            end else begin
                bus.controller_readdatavalid = 1'b0;
                bus.controller_readdata      = '0;
            end
            @(negedge clk);
            if (bus.cpu_rvalid) begin
                chk($sformatf("pipe_rdata%0d", got), bus.cpu_rdata, 32'(32'hA0000000 + got));
                got++;
            end
            if (bus.controller_chipselect && !bus.controller_read_n) begin
                r.due = c + 5;
                r.d   = 32'(32'hA0000000 + nc);
                pend.push_back(r);
                nc++;
            end
            if (bus.cpu_req && bus.cpu_ready && sent < 6) begin
                acc[sent] = c;
                sent++;
            end
            tick();
        end
        set_idle();
        chk("pipe_returned", got, 6);
        for (int i = 1; i < 4; i++)
            chk($sformatf("pipe_consec%0d", i), acc[i], acc[0] + i);
        chk("pipe_stall_until_return", acc[4], ret0 + 1);
        chk("pipe_sixth", acc[5], acc[4] + 1);
        @(negedge clk);
        chk("pipe_busy_end", 32'(bus.busy), 0);
        tick();

        // ---------------- spurious return ----------------
        bus.controller_readdatavalid = 1'b1;
        bus.controller_readdata      = 32'h11111111;
        @(negedge clk);
        chk("spur_err_before", 32'(bus.err_spurious), 0);
        tick();
        bus.controller_readdatavalid = 1'b0;
        @(negedge clk);
        chk("spur_err_set",  32'(bus.err_spurious), 1);
        chk("spur_rvalid",   32'(bus.cpu_rvalid), 0);
        chk("spur_busy",     32'(bus.busy), 0);
        tick();
        tick();
        @(negedge clk);
        chk("spur_err_sticky", 32'(bus.err_spurious), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("spur_err_cleared", 32'(bus.err_spurious), 0);
        tick();

        // ---------------- randomized traffic vs reference model ----------------
        pend.delete();
        cur.valid = 1'b0; cur.is_rd = 1'b0; cur.addr = '0; cur.ben_n = 4'hF; cur.wdata = '0;
        outst = 0; rdv_prev = 1'b0; rd_prev = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.cpu_req   = (cyc < 500) && ($urandom_range(0, 9) < 7);
            bus.cpu_we    = 1'($urandom_range(0, 1));
            bus.cpu_addr  = 27'($urandom);
            bus.cpu_be    = 4'($urandom);
            bus.cpu_wdata = $urandom;
            w = (cyc < 500) && ($urandom_range(0, 9) < 3);
            bus.controller_waitrequest = w;
            rdv = 1'b0;
            bus.controller_readdata = $urandom;
            if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(0, 3) != 0) begin
                rdv = 1'b1;
                bus.controller_readdata = pend[0].d;
                void'(pend.pop_front());
            end
            bus.controller_readdatavalid = rdv;
            @(negedge clk);
            chk("rnd_cs", 32'(bus.controller_chipselect), 32'(cur.valid));
            if (cur.valid) begin
                chk("rnd_read_n",  32'(bus.controller_read_n), 32'(!cur.is_rd));
                chk("rnd_write_n", 32'(bus.controller_write_n), 32'(cur.is_rd));
                chk("rnd_addr",    32'(bus.controller_address), 32'(cur.addr));
                chk("rnd_ben_n",   32'(bus.controller_byteenable_n), 32'(cur.ben_n));
                if (!cur.is_rd) chk("rnd_wdata", bus.controller_writedata, cur.wdata);
            end else begin
                chk("rnd_idle_rw_n", 32'({bus.controller_read_n, bus.controller_write_n}), 32'b11);
            end
            chk("rnd_rvalid", 32'(bus.cpu_rvalid), 32'(rdv_prev));
            if (rdv_prev) chk("rnd_rdata", bus.cpu_rdata, rd_prev);
            chk("rnd_busy", 32'(bus.busy), 32'(cur.valid || outst != 0));
            exp_rdy = (!cur.valid || !w) &&
                      (bus.cpu_we || (outst + ((cur.valid && cur.is_rd && !w) ? 1 : 0)) < MAX_RD);
            chk("rnd_ready", 32'(bus.cpu_ready), 32'(exp_rdy));
            chk("rnd_outstanding_limit", 32'(outst <= MAX_RD), 1);
            if (rdv) outst--;
            if (cur.valid && !w && cur.is_rd) begin
                outst++;
                r.due = cyc + int'($urandom_range(1, 8));
                r.d   = $urandom;
                pend.push_back(r);
            end
            acc_now = bus.cpu_req && bus.cpu_ready;
            if (acc_now && !bus.cpu_we) begin
                cur.valid = 1'b1; cur.is_rd = 1'b1;
                cur.addr  = bus.cpu_addr[26:2]; cur.ben_n = 4'h0;
            end else if (acc_now && bus.cpu_be != 4'h0) begin
                cur.valid = 1'b1; cur.is_rd = 1'b0;
                cur.addr  = bus.cpu_addr[26:2]; cur.ben_n = ~bus.cpu_be;
                cur.wdata = bus.cpu_wdata;
            end else if (acc_now || (cur.valid && !w)) begin
                cur.valid = 1'b0;
            end
            rdv_prev = rdv;
            rd_prev  = bus.controller_readdata;
            tick();
        end
        set_idle();
        @(negedge clk);
        chk("rnd_drained_outst", outst, 0);
        chk("rnd_drained_pend", pend.size(), 0);
        chk("rnd_busy_end", 32'(bus.busy), 0);
        chk("rnd_no_spurious", 32'(bus.err_spurious), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/sdram_avalon_master.md
# sdram_avalon_master

Avalon-MM master that drives the `controller_*` slave port of the SDRAM controller on behalf of the RISC-V core's data-memory path. It converts a simple CPU-side request/ready interface (byte address, active-high byte enables) into Avalon read/write commands. It honours `controller_waitrequest` and supports up to `MAX_RD` pipelined outstanding reads. Read data returns in order one cycle after `controller_readdatavalid`.

## Interface
- `MAX_RD`, default 4: maximum outstanding reads (1..15); the counter width is `$clog2(MAX_RD+1)`.
- `clk_clk  in  1`: the single clock; all logic is on its rising edge.
- `reset_reset  in  1`: reset, synchronous and active-high.
- `cpu_req  in  1`: request valid.
- `cpu_we  in  1`: 1 = write, 0 = read.
- `cpu_addr  in  27`: byte address; bits [1:0] are ignored.
- `cpu_be  in  4`: byte enables, active-high.
- `cpu_wdata  in  32`: write data.
- `cpu_ready  out  1`: request accepted on this edge when high together with `cpu_req`. Combinational.
- `cpu_rvalid  out  1`: read data valid. Single-cycle pulse with no backpressure.
- `cpu_rdata  out  32`: read data.
- `busy  out  1`: command pending or reads outstanding.
- `err_spurious  out  1`: sticky; readdatavalid seen with no read outstanding.
- `controller_address  out  25`: word address, equal to `cpu_addr[26:2]`.
- `controller_byteenable_n  out  4`: active-low byte enables.
- `controller_chipselect  out  1`
- `controller_writedata  out  32`
- `controller_read_n  out  1`
- `controller_write_n  out  1`
- `controller_readdata  in  32`
- `controller_readdatavalid  in  1`
- `controller_waitrequest  in  1`

## Operation
- **States.**
  - IDLE: no Avalon command is driven.
  - CMD: an Avalon command is driven from registers.
- **Reset values** (all outputs and internal state, applied on the edge with `reset_reset`=1):
  - state IDLE, `rd_cnt`=0.
  - `controller_chipselect`=0, `controller_read_n`=1, `controller_write_n`=1.
  - `controller_byteenable_n`=4'hF, `controller_address`=0, `controller_writedata`=0.
  - `cpu_rvalid`=0, `cpu_rdata`=0, `err_spurious`=0.
  - `cpu_ready`=0 while `reset_reset` is high.
- **`accept_slot`** = (state==IDLE) or (state==CMD and `controller_waitrequest`==0).
- **`cpu_ready`** = `accept_slot` and (`cpu_we` or `rd_cnt` + (CMD is a read being accepted this cycle) < `MAX_RD`). The decrement from a same-cycle readdatavalid is deliberately ignored, which is conservative.
- **On accept of a read:**
  - Latch `controller_address`=`cpu_addr[26:2]` and `controller_byteenable_n`=4'h0; all bytes are read and `cpu_be` is ignored.
  - Drive `controller_read_n`=0, `controller_write_n`=1, `controller_chipselect`=1; go to CMD.
- **On accept of a write with `cpu_be`!=0:**
  - Latch the address, `controller_byteenable_n`=~`cpu_be` and `controller_writedata`.
  - Drive `controller_write_n`=0, `controller_read_n`=1, `controller_chipselect`=1; go to CMD.
- **Write with `cpu_be`==0:** accepted, but no Avalon command is issued. The next state is IDLE, with the command signals deasserted.
- **CMD hold:** while `controller_waitrequest`=1, all `controller_*` outputs hold stable.
- **CMD completion:** when `controller_waitrequest`=0 the command completes on that edge.
  - If it is a read, `rd_cnt` increments.
  - If a new request is accepted on the same edge, stay in CMD with the new fields (back-to-back issue).
  - Otherwise go to IDLE with chipselect=0, read_n=1, write_n=1.
- **Read return:** on `controller_readdatavalid`=1 with `rd_cnt`>0, `cpu_rdata` is set to `controller_readdata`, `cpu_rvalid` is 1 on the next cycle, and `rd_cnt` decrements.
- **Simultaneous increment and decrement:** `rd_cnt` is unchanged.
- **Spurious return:** `controller_readdatavalid` with `rd_cnt`==0 sets `err_spurious` (cleared only by reset). `cpu_rvalid` stays 0 and `rd_cnt` stays 0.
- **`busy`** = (state==CMD) or (`rd_cnt`!=0).
- **Reset mid-operation:** the pending command and outstanding reads are dropped. The controller shares the reset, so stray returns must not occur; any that do set `err_spurious`.
- **Write ordering:** in-order issue is guaranteed. No hazard checking is done, because the controller preserves order.

## Timing
- All `controller_*` outputs, `cpu_rvalid` and `cpu_rdata` are registered.
- `cpu_ready` has a combinational path from `controller_waitrequest`, `cpu_we` and state.
- **Issue latency:** a request accepted at edge N drives the Avalon command during cycle N+1 (after edge N).
- **Throughput:** with `controller_waitrequest`=0 and requests continuously present, one command is issued per cycle.
- **Read return latency:** `controller_readdatavalid` high in cycle M gives `cpu_rvalid` high in cycle M+1 with the matching data.
- **Outstanding limit:** with `rd_cnt`=`MAX_RD`, reads stall (`cpu_ready`=0) but writes are still accepted.

## Test plan
- **Reset:** hold `reset_reset` for 2 cycles → every output equals its reset value, and `cpu_ready`=0 during reset and 1 after.
- **Single read:**
  - Stimulus: read at `cpu_addr`=0x0000104, and the controller model returns 0xDEADBEEF 3 cycles after accept.
  - Required response: `controller_address`=0x41, `controller_byteenable_n`=0, `cpu_rvalid` for one cycle with 0xDEADBEEF, and `busy` then drops to 0.
- **Write under waitrequest:**
  - Stimulus: write `cpu_be`=4'b0011, data 0x12345678, with waitrequest held high for 4 cycles.
  - Required response: outputs stable for all 4 cycles, `controller_byteenable_n`=4'b1100, and `cpu_ready`=0 until waitrequest falls.
- **Pipelined reads:**
  - Stimulus: `MAX_RD`=4, 6 back-to-back reads, no waitrequest, return latency 5.
  - Required response: 4 issued in consecutive cycles, 5th stalls until the first return, and all 6 data words come back in order.
- **Zero byte enables:** write with `cpu_be`=0 → accepted, `controller_chipselect` never asserts, `busy` stays 0.
- **Spurious return:** `controller_readdatavalid` pulsed with nothing outstanding → `err_spurious`=1 sticky, `cpu_rvalid` stays 0, and it is cleared by reset.
